// File: rtl/inst_queue.sv
// Circular fetch-to-decode instruction buffer: two-wide enqueue, two-wide in-order dequeue.
// Optional iq_full_cycles_o performance counter is enabled by defining IQ_PERF_CNT_EN.

module inst_queue_lane #(
    parameter int LANE  = 0,
    parameter int CNT_W = 5,
    parameter int ENT_W = 96
) (
    input  logic [CNT_W-1:0] count,
    input  logic [ENT_W-1:0] entry,
    output logic             valid,
    output logic [ENT_W-1:0] data
);
    // Lane n is valid once more than n entries are held; invalid lanes read as zero.
    assign valid = (count > CNT_W'(LANE));
    assign data  = valid ? entry : '0;
endmodule

module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_iq_i,
    input  logic             stall_iq_i,
    input  logic             fetch_inst0_valid_i,
    input  logic [63:0]      fetch_inst0_pc_i,
    input  logic [31:0]      fetch_inst0_inst_i,
    input  logic             fetch_inst1_valid_i,
    input  logic [63:0]      fetch_inst1_pc_i,
    input  logic [31:0]      fetch_inst1_inst_i,
    output logic             iq_ready_o,
    output logic             inst0_f1_valid_o,
    output logic [63:0]      inst0_f1_pc_o,
    output logic [31:0]      inst0_f1_inst_o,
    output logic             inst1_f1_valid_o,
    output logic [63:0]      inst1_f1_pc_o,
    output logic [31:0]      inst1_f1_inst_o,
    output logic [PTR_W:0]   iq_count_o,
    output logic [31:0]      iq_full_cycles_o
);
    localparam int CNT_W     = PTR_W + 1;
    localparam int NUM_LANES = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    localparam int ENT_W = $bits(iq_entry_t);

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] free_slots;
    logic             accept0, accept1;
    logic [1:0]       n_enq, n_deq;
    logic             deq_en;
    logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;

    assign free_slots = CNT_W'(DEPTH) - count;
    assign iq_ready_o = !rst && (free_slots >= CNT_W'(2));

    // Slot 1 is only taken behind slot 0, so fetch can never leave a hole.
    assign accept0 = iq_ready_o && !flush_iq_i && fetch_inst0_valid_i;
    assign accept1 = accept0 && fetch_inst1_valid_i;
    assign n_enq   = {1'b0, accept0} + {1'b0, accept1};

    assign deq_en = !stall_iq_i && !flush_iq_i;
    assign n_deq  = !deq_en                ? 2'd0 :
                    (count >= CNT_W'(2))   ? 2'd2 : count[1:0];

    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_iq_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_enq);
            rd_ptr <= rd_ptr + PTR_W'(n_deq);
            count  <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (accept0) mem[wr_ptr]    <= '{pc: fetch_inst0_pc_i, inst: fetch_inst0_inst_i};
        if (accept1) mem[wr_ptr_p1] <= '{pc: fetch_inst1_pc_i, inst: fetch_inst1_inst_i};
    end

    logic [NUM_LANES-1:0][ENT_W-1:0] head_entry;
    logic [NUM_LANES-1:0][ENT_W-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid;

    assign head_entry[0] = mem[rd_ptr];
    assign head_entry[1] = mem[rd_ptr_p1];

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            inst_queue_lane #(
                .LANE  (g),
                .CNT_W (CNT_W),
                .ENT_W (ENT_W)
            ) u_lane (
                .count (count),
                .entry (head_entry[g]),
                .valid (lane_valid[g]),
                .data  (lane_data[g])
            );
        end
    endgenerate

    iq_entry_t out0, out1;
    assign out0 = iq_entry_t'(lane_data[0]);
    assign out1 = iq_entry_t'(lane_data[1]);

    assign inst0_f1_valid_o = lane_valid[0];
    assign inst0_f1_pc_o    = out0.pc;
    assign inst0_f1_inst_o  = out0.inst;
    assign inst1_f1_valid_o = lane_valid[1];
    assign inst1_f1_pc_o    = out1.pc;
    assign inst1_f1_inst_o  = out1.inst;
    assign iq_count_o       = count;

`ifdef IQ_PERF_CNT_EN
    logic [31:0] full_cycles;

    // Counts back-pressure cycles seen by fetch; survives flush, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            full_cycles <= '0;
        else if (!iq_ready_o && full_cycles != 32'hFFFF_FFFF)
            full_cycles <= full_cycles + 32'd1;
    end

    assign iq_full_cycles_o = full_cycles;
`else
    assign iq_full_cycles_o = 32'h0;
`endif

endmodule
